// File: rtl/led_ctrl_pkg.sv
// led_ctrl_pkg: mode encodings, per-mode initial LED patterns and field widths for led_mode_ctrl
package led_ctrl_pkg;
    localparam int MODE_W  = 2;
    localparam int SPEED_W = 2;
    typedef enum logic [MODE_W-1:0] {FLOW_L, FLOW_R, BLINK, PINGPONG} mode_e;
    localparam logic [3:0] INIT_FLOW_L   = 4'b0001;
    localparam logic [3:0] INIT_FLOW_R   = 4'b1000;
    localparam logic [3:0] INIT_BLINK    = 4'b1111;
    localparam logic [3:0] INIT_PINGPONG = 4'b0001;
    function automatic logic [3:0] init_pat(input mode_e m);
        return m == FLOW_L ? INIT_FLOW_L :
               m == FLOW_R ? INIT_FLOW_R :
               m == BLINK  ? INIT_BLINK  : INIT_PINGPONG;
    endfunction
endpackage

// File: rtl/key_debounce.sv
// key_debounce: synchronize, debounce and edge-detect one active-low push-button
//   clk, rst_n : clock, asynchronous active-low reset
//   key        : raw active-low button, asynchronous to clk
//   press      : one-cycle pulse on each debounced press (1->0); release gives nothing
module key_debounce #(
    parameter int DEB_CYC = 1_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key,
    output logic press
);
    localparam int CW = $clog2(DEB_CYC + 1);
    logic [1:0]    sync;
    logic [CW-1:0] cnt;
    logic          deb, deb_d;
    // The level flips on the DEB_CYC-th consecutive cycle of disagreement.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync  <= 2'b11;
            cnt   <= '0;
            deb   <= 1'b1;
            deb_d <= 1'b1;
            press <= 1'b0;
        end else begin
            sync  <= {sync[0], key};
            deb_d <= deb;
            press <= deb_d & ~deb;
            if (sync[1] == deb)
                cnt <= '0;
            else if (cnt == CW'(DEB_CYC - 1)) begin
                cnt <= '0;
                deb <= sync[1];
            end else
                cnt <= cnt + 1'b1;
        end
    end
endmodule

// File: rtl/led_mode_ctrl.sv
// led_mode_ctrl: two-button mode/speed controller driving a 4-bit LED pattern
//   clk, rst_n          : clock, asynchronous active-low reset
//   key_mode, key_speed : active-low buttons, asynchronous to clk
//   led                 : LED drive, 1 = on
//   mode, speed         : current display mode (FLOW_L/FLOW_R/BLINK/PINGPONG) and rate index
//   step                : one-cycle pulse the cycle before each pattern step is visible
// Optional LED_DIM_EN: gates led with an 8-bit PWM (on while pwm_cnt < DIM_DUTY).
module led_mode_ctrl
    import led_ctrl_pkg::*;
#(
    parameter int TICK_CYC = 12_500_000,
    parameter int DEB_CYC  = 1_000_000
`ifdef LED_DIM_EN
    , parameter int DIM_DUTY = 64
`endif
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               key_mode,
    input  logic               key_speed,
    output logic [3:0]         led,
    output logic [MODE_W-1:0]  mode,
    output logic [SPEED_W-1:0] speed,
    output logic               step
);
    localparam int CW = $clog2(TICK_CYC);
    logic               mode_press, speed_press, any_press, tick;
    logic [CW-1:0]      cnt, last;
    mode_e              mode_q, mode_nx;
    logic [SPEED_W-1:0] speed_q;
    logic [3:0]         led_q, led_nx;
    logic               dir_l, dir_nx;

    key_debounce #(.DEB_CYC(DEB_CYC)) u_key_mode (
        .clk(clk), .rst_n(rst_n), .key(key_mode), .press(mode_press)
    );
    key_debounce #(.DEB_CYC(DEB_CYC)) u_key_speed (
        .clk(clk), .rst_n(rst_n), .key(key_speed), .press(speed_press)
    );

    assign last      = CW'((TICK_CYC >> speed_q) - 1);
    assign any_press = mode_press | speed_press;
    assign tick      = cnt == last;
    // A press restarts the period, so a coinciding step is dropped.
    assign step      = tick & ~any_press;
    assign mode_nx   = mode_press ? mode_e'(mode_q + 2'd1) : mode_q;
    assign mode      = mode_q;
    assign speed     = speed_q;

    always_comb begin
        led_nx = led_q;
        dir_nx = dir_l;
        if (mode_press) begin
            led_nx = init_pat(mode_nx);
            dir_nx = 1'b1;
        end else if (step) begin
            case (mode_q)
                FLOW_L:  led_nx = {led_q[2:0], led_q[3]};
                FLOW_R:  led_nx = {led_q[0], led_q[3:1]};
                BLINK:   led_nx = ~led_q;
                default: begin
                    led_nx = dir_l ? led_q << 1 : led_q >> 1;
                    dir_nx = led_nx == 4'b1000 ? 1'b0 : led_nx == 4'b0001 ? 1'b1 : dir_l;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            mode_q  <= FLOW_L;
            speed_q <= '0;
            led_q   <= INIT_FLOW_L;
            dir_l   <= 1'b1;
        end else begin
            cnt     <= (any_press || tick) ? '0 : cnt + 1'b1;
            mode_q  <= mode_nx;
            speed_q <= speed_press ? speed_q + 1'b1 : speed_q;
            led_q   <= led_nx;
            dir_l   <= dir_nx;
        end
    end

`ifdef LED_DIM_EN
    logic [7:0] pwm_cnt;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            pwm_cnt <= '0;
        else
            pwm_cnt <= pwm_cnt + 1'b1;
    end
    assign led = led_q & {4{{1'b0, pwm_cnt} < 9'(DIM_DUTY)}};
`else
    assign led = led_q;
`endif
endmodule

// File: tb/tb_led_mode_ctrl.sv
// tb_led_mode_ctrl: randomized button stimulus checked against a step-count reference model
module tb_led_mode_ctrl;
    localparam int TICK = 16;
    localparam int DEB  = 4;
    // Key drive at cycle E takes effect on edge E+8 (2 sync + DEB + 1 pulse + 1 update).
    localparam int LAT  = 2 + DEB + 2;

    logic       clk = 1'b0;
    logic       rst_n, key_mode, key_speed, step;
    logic [3:0] led;
    logic [1:0] mode, speed;

    int errors = 0, checks = 0;
    int ec, t_clr, m, s, k, pend_m, pend_s;
    int mode_lo, spd_lo, mode_free, spd_free;

    led_mode_ctrl #(.TICK_CYC(TICK), .DEB_CYC(DEB)) dut (
        .clk(clk), .rst_n(rst_n), .key_mode(key_mode), .key_speed(key_speed),
        .led(led), .mode(mode), .speed(speed), .step(step)
    );

    always #10 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, ec);
        end
    endtask

    // Pattern after k steps since the mode was entered.
    function automatic logic [3:0] pat(input int md, input int kk);
        int p;
        p = kk % 6;
        case (md)
            0:       return 4'(1 << (kk % 4));
            1:       return 4'(8 >> (kk % 4));
            2:       return (kk % 2) ? 4'b0000 : 4'b1111;
            default: return p <= 3 ? 4'(1 << p) : 4'(1 << (6 - p));
        endcase
    endfunction

    function automatic int period(input int sp);
        return TICK >> sp;
    endfunction

    task automatic model_reset();
        ec = 0; t_clr = 0; m = 0; s = 0; k = 0;
        pend_m = -1; pend_s = -1;
        mode_lo = 0; spd_lo = 0; mode_free = 0; spd_free = 0;
        key_mode = 1'b1; key_speed = 1'b1;
    endtask

    task automatic model_edge(input int e);
        bit mp, sp;
        mp = pend_m == e;
        sp = pend_s == e;
        if (mp || sp) begin
            if (mp) begin
                m = (m + 1) % 4;
                k = 0;
            end
            if (sp) s = (s + 1) % 4;
            t_clr = e;
        end else if ((e - t_clr) % period(s) == 0)
            k++;
    endtask

    task automatic drive_keys();
        int l;
        if (mode_lo == 0 && ec >= mode_free && $urandom_range(0, 24) == 0) begin
            l = $urandom_range(1, 9);
            mode_lo = l;
            mode_free = ec + l + 12;
            if (l >= DEB) pend_m = ec + LAT;
        end
        if (spd_lo == 0 && ec >= spd_free && $urandom_range(0, 40) == 0) begin
            l = $urandom_range(1, 9);
            spd_lo = l;
            spd_free = ec + l + 12;
            if (l >= DEB) pend_s = ec + LAT;
        end
        key_mode  = mode_lo > 0 ? 1'b0 : 1'b1;
        key_speed = spd_lo > 0 ? 1'b0 : 1'b1;
        if (mode_lo > 0) mode_lo--;
        if (spd_lo > 0) spd_lo--;
    endtask

    task automatic run(input int n);
        bit exp_step;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            ec++;
            model_edge(ec);
            #1 drive_keys();
            @(negedge clk);
            exp_step = ((ec + 1 - t_clr) % period(s) == 0) && pend_m != ec + 1 && pend_s != ec + 1;
            check("led", 8'(led), 8'(pat(m, k)));
            check("mode", 8'(mode), 8'(m));
            check("speed", 8'(speed), 8'(s));
            check("step", 8'(step), 8'(exp_step));
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_led"}, 8'(led), 8'h01);
        check({tag, "_mode"}, 8'(mode), 8'h00);
        check({tag, "_speed"}, 8'(speed), 8'h00);
        check({tag, "_step"}, 8'(step), 8'h00);
    endtask

    task automatic async_reset(input string tag);
        @(negedge clk);
        #3 rst_n = 1'b0;
        #1 check_reset_vals(tag);
        model_reset();
        repeat (3) @(negedge clk);
        check_reset_vals({tag, "_hold"});
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        model_reset();
        #200;
        check_reset_vals("por");
        rst_n = 1'b1;
        run(1500);
        async_reset("mid1");
        run(1200);
        async_reset("mid2");
        run(800);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
